// File: rtl/multiplicador_secuencial_pkg.sv
// Shared fixed-point format constants for the multiplier and the truncation stage.
// Pure constants, no logic, so no latency.
// No handshaking: importers pick these up as parameter defaults.
package multiplicador_secuencial_pkg;

    // Operand format Q(M).(F) with one sign bit: N = 1 + M + F
    localparam int N_BITS = 16;
    localparam int M_BITS = 7;
    localparam int F_BITS = 8;

endpackage : multiplicador_secuencial_pkg

// File: rtl/multiplicador_secuencial_paso_booth.sv
// One radix-2 Booth step: conditional add/sub of the multiplicand into hi, then arithmetic shift.
// Latency: purely combinational, zero cycles.
// No backpressure: the controller decides when the result is registered.
import multiplicador_secuencial_pkg::*;

module multiplicador_secuencial_paso_booth #(
    parameter int N = N_BITS
) (
    input  logic [N:0]   hi_i,
    input  logic [N-1:0] lo_i,
    input  logic         qm1_i,
    input  logic [N:0]   mcand_i,
    output logic [N:0]   hi_o,
    output logic [N-1:0] lo_o,
    output logic         qm1_o
);

    logic [N:0] suma;

    // Booth recoding of {lo[0], q_-1}, then shift {hi, lo, q_-1} right by one keeping the sign
    always_comb begin
        suma = hi_i;
        case ({lo_i[0], qm1_i})
            2'b10:   suma = hi_i - mcand_i;
            2'b01:   suma = hi_i + mcand_i;
            default: suma = hi_i;
        endcase
        hi_o  = {suma[N], suma[N:1]};
        lo_o  = {suma[0], lo_i[N-1:1]};
        qm1_o = lo_i[0];
    end

endmodule : multiplicador_secuencial_paso_booth

// File: rtl/multiplicador_secuencial.sv
// Sequential signed Q(M).(F) Booth multiplier producing the full 2N-bit product plus a saturation flag.
// Latency: operands sampled on the accepting edge, result and valido one cycle after N further edges.
// inicio is ignored while ocupado is high; inicio during the valido cycle is accepted back-to-back.
import multiplicador_secuencial_pkg::*;

module multiplicador_secuencial #(
    parameter int N = N_BITS,
    parameter int M = M_BITS,
    parameter int F = F_BITS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inicio,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] producto,
    output logic           valido,
    output logic           ocupado,
    output logic           desborde
);

    localparam int CW    = $clog2(N);
    // Bits above the narrowed integer field: all must match the sign for truncation to be lossless
    localparam int OVF_W = 2*N - (2*F + M);

    typedef enum logic {
        REPOSO  = 1'b0,
        CALCULO = 1'b1
    } estado_t;

    estado_t        estado_q;
    logic [N:0]     mcand_q;
    logic [N:0]     hi_q;
    logic [N-1:0]   lo_q;
    logic           qm1_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] producto_q;
    logic           valido_q;
    logic           ocupado_q;
    logic           desborde_q;

    logic [N:0]     hi_d;
    logic [N-1:0]   lo_d;
    logic           qm1_d;
    logic [2*N-1:0] producto_d;
    logic [OVF_W-1:0] cabeza;
    logic           desborde_d;

    multiplicador_secuencial_paso_booth #(
        .N (N)
    ) u_paso (
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .qm1_i   (qm1_q),
        .mcand_i (mcand_q),
        .hi_o    (hi_d),
        .lo_o    (lo_d),
        .qm1_o   (qm1_d)
    );

    // Candidate product after the current step and its saturation flag
    always_comb begin
        producto_d = {hi_d[N-1:0], lo_d};
        cabeza     = producto_d[2*N-1:2*F+M];
        desborde_d = !((&cabeza) || (~|cabeza));
    end

    // Controller: accept operands, run N Booth steps, publish the registered result
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q   <= REPOSO;
            mcand_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            qm1_q      <= 1'b0;
            cnt_q      <= '0;
            producto_q <= '0;
            valido_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            valido_q <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (inicio) begin
                        mcand_q   <= {a[N-1], a};
                        hi_q      <= '0;
                        lo_q      <= b;
                        qm1_q     <= 1'b0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= CALCULO;
                    end
                end
                CALCULO: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N-1)) begin
                        producto_q <= producto_d;
                        desborde_q <= desborde_d;
                        valido_q   <= 1'b1;
                        ocupado_q  <= 1'b0;
                        cnt_q      <= '0;
                        estado_q   <= REPOSO;
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign producto = producto_q;
    assign valido   = valido_q;
    assign ocupado  = ocupado_q;
    assign desborde = desborde_q;

endmodule : multiplicador_secuencial

// File: tb/tb_multiplicador_secuencial.sv
// Directed self-checking bench for the sequential Booth multiplier.
// Expected products are hand-computed fixed-point values.
// Inputs change 1ns after rising edges; outputs are sampled at the same point.
module tb_multiplicador_secuencial;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] producto;
    logic        valido;
    logic        ocupado;
    logic        desborde;

    int checks = 0;
    int errors = 0;
    int edges;
    int pulsos;

    multiplicador_secuencial dut (
        .clk      (clk),
        .reset    (reset),
        .inicio   (inicio),
        .a        (a),
        .b        (b),
        .producto (producto),
        .valido   (valido),
        .ocupado  (ocupado),
        .desborde (desborde)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with inicio for one edge (E0)
    task automatic arrancar(input logic [15:0] va, input logic [15:0] vb);
        a      = va;
        b      = vb;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
    endtask

    // Count edges until valido, bounded so a dead DUT still reaches the summary
    task automatic esperar_valido(output int n);
        n = 0;
        while (valido !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        reset  = 1'b0;
        inicio = 1'b0;
        a      = '0;
        b      = '0;
        step();
        step();
        chk("reset_producto", producto, 32'h0);
        chk("reset_valido", {31'b0, valido}, 32'h0);
        chk("reset_ocupado", {31'b0, ocupado}, 32'h0);
        chk("reset_desborde", {31'b0, desborde}, 32'h0);
        reset = 1'b1;
        step();

        // 1.5 x 2.0
        arrancar(16'h0180, 16'h0200);
        chk("ocupado_tras_inicio", {31'b0, ocupado}, 32'h1);
        esperar_valido(edges);
        chk("latencia_1p5x2", edges, 16);
        chk("prod_1p5x2", producto, 32'h00030000);
        chk("desb_1p5x2", {31'b0, desborde}, 32'h0);
        chk("ocupado_en_valido", {31'b0, ocupado}, 32'h0);
        step();
        chk("valido_un_ciclo", {31'b0, valido}, 32'h0);
        chk("prod_retenido", producto, 32'h00030000);

        // -1.0 x 0.5
        arrancar(16'hFF00, 16'h0080);
        esperar_valido(edges);
        chk("latencia_m1x0p5", edges, 16);
        chk("prod_m1x0p5", producto, 32'hFFFF8000);
        chk("desb_m1x0p5", {31'b0, desborde}, 32'h0);
        step();

        // Most negative squared must be exact
        arrancar(16'h8000, 16'h8000);
        esperar_valido(edges);
        chk("prod_min_cuadrado", producto, 32'h40000000);
        chk("desb_min_cuadrado", {31'b0, desborde}, 32'h1);
        step();

        // 100.0 x 100.0 saturates on truncation
        arrancar(16'h6400, 16'h6400);
        esperar_valido(edges);
        chk("prod_100x100", producto, 32'h27100000);
        chk("desb_100x100", {31'b0, desborde}, 32'h1);
        step();

        // Reset in the middle of an operation
        arrancar(16'h8000, 16'h8000);
        repeat (7) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_ocupado", {31'b0, ocupado}, 32'h0);
        chk("rst_mid_producto", producto, 32'h0);
        chk("rst_mid_desborde", {31'b0, desborde}, 32'h0);
        pulsos = 0;
        for (int i = 0; i < 24; i++) begin
            if (valido === 1'b1) pulsos++;
            step();
        end
        chk("rst_mid_sin_valido", pulsos, 0);

        // Fresh operation after the aborted one
        arrancar(16'hFF00, 16'h0080);
        esperar_valido(edges);
        chk("latencia_tras_rst", edges, 16);
        chk("prod_tras_rst", producto, 32'hFFFF8000);
        step();

        // inicio while busy is ignored, operands change freely
        arrancar(16'h0180, 16'h0200);
        a = 16'h1234;
        b = 16'h4321;
        repeat (5) step();
        a      = 16'h7FFF;
        b      = 16'h7FFF;
        inicio = 1'b1;
        step();
        inicio = 1'b0;
        a      = 16'hAAAA;
        b      = 16'h5555;
        chk("ocupado_ignora_inicio", {31'b0, ocupado}, 32'h1);
        esperar_valido(edges);
        chk("latencia_ignora", edges, 10);
        chk("prod_ignora", producto, 32'h00030000);
        chk("desb_ignora", {31'b0, desborde}, 32'h0);

        // Back-to-back: inicio in the valido cycle
        arrancar(16'h0100, 16'hFE00);
        chk("b2b_valido_bajo", {31'b0, valido}, 32'h0);
        chk("b2b_ocupado", {31'b0, ocupado}, 32'h1);
        chk("b2b_prod_retenido", producto, 32'h00030000);
        esperar_valido(edges);
        chk("latencia_b2b", edges, 16);
        chk("prod_b2b", producto, 32'hFFFE0000);
        chk("desb_b2b", {31'b0, desborde}, 32'h0);
        step();
        chk("b2b_valido_cae", {31'b0, valido}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_multiplicador_secuencial

// File: doc/multiplicador_secuencial.md
Name: multiplicador_secuencial

Overview:
- Sequential signed fixed-point multiplier. Produces the full-width 2N-bit Q(2M).(2F) product that the truncation/saturation stage consumes and narrows back to N bits.
- Radix-2 Booth multiplier: one Booth step per clock, valid/busy handshake toward the datapath controller.
- Also flags, ahead of time, whether truncation will saturate.

Parameters:
- N, 16, total operand width (sign + M + F); must equal 1+M+F.
- M, 7, integer bits (excluding sign).
- F, 8, fractional bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- inicio  input  1  start request; operands sampled when accepted.
- a  input  N  signed multiplicand, Q(M).(F).
- b  input  N  signed multiplier, Q(M).(F).
- producto  output  2N  signed product, Q(2M).(2F); held until the next result.
- valido  output  1  one-cycle pulse: producto updated.
- ocupado  output  1  high while a multiplication is in progress.
- desborde  output  1  registered with producto; 1 when producto[2N-1:2F+M] is not all-equal (truncation to N bits will saturate).

Behaviour:
- Reset (reset==0 at an edge): state=REPOSO, producto=0, valido=0, ocupado=0, desborde=0, counter=0. Applies mid-operation: any in-flight result is discarded and no valido is issued.
- States: REPOSO, CALCULO.
- REPOSO:
  - If inicio==1 at edge E0: latch a into the multiplicand register (sign-extended to N+1 bits).
  - Load accumulator {hi[N:0]=0, lo=b, q_-1=0} and set counter=0.
  - ocupado=1, go to CALCULO.
  - If inicio==0: stay; outputs hold.
- CALCULO, per edge:
  - Booth pair {lo[0], q_-1}: 10 → hi -= mcand; 01 → hi += mcand; 00/11 → no-op.
  - Then arithmetic shift right of {hi, lo, q_-1} by 1; counter++.
  - hi is N+1 bits so that a = -2^(N-1) never overflows.
- Completion:
  - At edge EN (N-th step, counter reaches N-1 before the step): producto = {hi[N-1:0], lo} after the final shift, desborde computed from that value, valido=1, ocupado=0, state=REPOSO.
  - Latency: operands sampled at E0 → valido high in the cycle after EN (N edges).
- valido is high for exactly one cycle and cleared at the next edge unless a new completion occurs.
- inicio while ocupado==1 is ignored; operands are not resampled.
- inicio high during the valido cycle (state REPOSO) is accepted, giving back-to-back operation with throughput of one result per N+1 cycles minimum.
- a and b may change freely after E0.
- Exact product: -2^(N-1) × -2^(N-1) = 2^(2N-2) is representable and must be exact.
- No rounding; the full-precision product is output.

Decomposition:
- N, M, F come from the shared constants header, the same one used by the truncation stage. Module parameter defaults reference it.
- State encoding (REPOSO=1'b0, CALCULO=1'b1) is local.
- Natural sub-module: paso_booth (combinational one-step add/sub + arithmetic shift, N+1-bit hi). Controller and counter stay in the top module.
- desborde logic is an inline compare, not a separate module.

Test Plan:
- 1.5×2.0: a=16'h0180, b=16'h0200, inicio 1 cycle → after 16 edges valido=1, producto=32'h00030000, desborde=0; valido low the next cycle.
- -1.0×0.5: a=16'hFF00, b=16'h0080 → producto=32'hFFFF8000, desborde=0.
- Most-negative squared: a=b=16'h8000 → producto=32'h40000000, desborde=1.
- Overflow: a=b=16'h6400 (100.0) → producto=32'h27100000, desborde=1.
- Busy/back-to-back:
  - Pulse inicio again at step 5 with different operands → ignored; first result is unchanged.
  - Assert inicio in the valido cycle with a=16'h0100, b=16'hFE00 → second result 32'hFFFE0000 exactly 16 edges later.
- Reset mid-op: drive reset=0 at step 8 for one edge → ocupado=0, producto=0; valido never pulses for that operation. A fresh inicio afterwards yields the correct result.
